// File: rtl/data_mem_unit.sv
// RV32I data memory stage: lane select, sign/zero extend, byte-enable stores; load result 1 cycle after accept (2 if split).
// No ready input; split accesses raise stall for one cycle and any request presented meanwhile is dropped.
module data_mem_unit #(
   parameter int XLEN        = 32,
   parameter int DEPTH_WORDS = 1024,
   parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            req_valid,
   input  logic            is_load,
   input  logic            is_store,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] addr,
   input  logic [XLEN-1:0] w_data,
   output logic [XLEN-1:0] r_data,
   output logic            r_valid,
   output logic            stall,
   output logic            err
);

   typedef enum logic {S_IDLE, S_SECOND} state_t;

   state_t            r_state;
   state_t            w_state_nxt;

   logic [XLEN-1:0]   r_mem [DEPTH_WORDS];
   logic [XLEN-1:0]   r_rd_word;
   logic [XLEN-1:0]   r_lo_word;

   logic [1:0]        r_sec_off;
   logic [2:0]        r_sec_f3;
   logic              r_sec_ld;
   logic              r_sec_st;
   logic [IDX_W-1:0]  r_idx2;
   logic [3:0]        r_hi_be;
   logic [XLEN-1:0]   r_hi_dat;

   logic              r_fin_vld;
   logic              r_fin_split;
   logic [1:0]        r_fin_off;
   logic [2:0]        r_fin_f3;

   logic [IDX_W-1:0]  w_k;
   logic [1:0]        w_off;
   logic [2:0]        w_size;
   logic [7:0]        w_bmask;
   logic [7:0]        w_be8;
   logic [63:0]       w_st64;
   logic              w_split;
   logic              w_bad;
   logic              w_act;
   logic              w_acc;
   logic              w_err;
   logic              w_ld_aligned;

   logic [IDX_W-1:0]  w_me_idx;
   logic              w_me_we;
   logic              w_me_re;
   logic [3:0]        w_me_be;
   logic [XLEN-1:0]   w_me_wd;

   logic [55:0]       w_fin56;
   logic [XLEN-1:0]   w_ld_raw;
   logic [XLEN-1:0]   w_ld_ext;
   logic              w_unused_addr;

   assign w_k           = addr[IDX_W+1:2];
   assign w_off         = addr[1:0];
   assign w_unused_addr = ^addr[XLEN-1:IDX_W+2];
   assign stall         = (r_state == S_SECOND);

   always_comb begin
      w_size  = 3'd4;
      w_bmask = 8'h0F;
      case (funct3[1:0])
         2'b00:   begin w_size = 3'd1; w_bmask = 8'h01; end
         2'b01:   begin w_size = 3'd2; w_bmask = 8'h03; end
         default: begin w_size = 3'd4; w_bmask = 8'h0F; end
      endcase
   end

   // Byte lanes laid out across two words; the upper word feeds the second access.
   assign w_be8   = w_bmask << w_off;
   assign w_st64  = {32'b0, w_data} << {w_off, 3'b000};
   assign w_split = ({2'b00, w_off} + {1'b0, w_size}) > 4'd4;

   assign w_bad = (funct3 == 3'b011) || (funct3[2:1] == 2'b11) ||
                  (is_load && is_store) || (is_store && funct3[2]);
   assign w_act = req_valid && rst_n && (is_load || is_store) && (r_state == S_IDLE);
   assign w_acc = w_act && !w_bad;
   assign w_err = w_act && w_bad;
   assign w_ld_aligned = w_acc && is_load && !w_split;

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:   if (w_acc && w_split) w_state_nxt = S_SECOND;
         S_SECOND: w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   // Single array port: the second half of a split owns it for one cycle.
   always_comb begin
      w_me_idx = w_k;
      w_me_we  = 1'b0;
      w_me_re  = 1'b0;
      w_me_be  = w_be8[3:0];
      w_me_wd  = w_st64[31:0];
      if (r_state == S_SECOND) begin
         w_me_idx = r_idx2;
         w_me_we  = r_sec_st && rst_n;
         w_me_re  = r_sec_ld && rst_n;
         w_me_be  = r_hi_be;
         w_me_wd  = r_hi_dat;
      end else begin
         w_me_we  = w_acc && is_store;
         w_me_re  = w_acc && is_load;
      end
   end

   always_ff @(posedge clk) begin
      if (w_me_we) begin
         for (int b = 0; b < 4; b++) begin
            if (w_me_be[b]) r_mem[w_me_idx][8*b +: 8] <= w_me_wd[8*b +: 8];
         end
      end
      if (w_me_re) r_rd_word <= r_mem[w_me_idx];
   end

   assign w_fin56  = r_fin_split ? {r_rd_word[23:0], r_lo_word} : {24'b0, r_rd_word};
   assign w_ld_raw = w_fin56[{r_fin_off, 3'b000} +: 32];

   always_comb begin
      w_ld_ext = w_ld_raw;
      case (r_fin_f3)
         3'b000:  w_ld_ext = {{24{w_ld_raw[7]}}, w_ld_raw[7:0]};
         3'b001:  w_ld_ext = {{16{w_ld_raw[15]}}, w_ld_raw[15:0]};
         3'b100:  w_ld_ext = {24'b0, w_ld_raw[7:0]};
         3'b101:  w_ld_ext = {16'b0, w_ld_raw[15:0]};
         default: w_ld_ext = w_ld_raw;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_data      <= '0;
         r_valid     <= 1'b0;
         err         <= 1'b0;
         r_fin_vld   <= 1'b0;
         r_fin_split <= 1'b0;
         r_fin_off   <= 2'b00;
         r_fin_f3    <= 3'b000;
         r_lo_word   <= '0;
         r_sec_off   <= 2'b00;
         r_sec_f3    <= 3'b000;
         r_sec_ld    <= 1'b0;
         r_sec_st    <= 1'b0;
         r_idx2      <= '0;
         r_hi_be     <= 4'b0000;
         r_hi_dat    <= '0;
      end else begin
         err       <= w_err;
         r_valid   <= r_fin_vld;
         r_fin_vld <= w_ld_aligned || (stall && r_sec_ld);
         if (r_fin_vld) r_data <= w_ld_ext;
         if (w_ld_aligned) begin
            r_fin_split <= 1'b0;
            r_fin_off   <= w_off;
            r_fin_f3    <= funct3;
         end
         if (stall) begin
            r_fin_split <= 1'b1;
            r_fin_off   <= r_sec_off;
            r_fin_f3    <= r_sec_f3;
            r_lo_word   <= r_rd_word;
         end
         if (w_acc && w_split) begin
            r_sec_off <= w_off;
            r_sec_f3  <= funct3;
            r_sec_ld  <= is_load;
            r_sec_st  <= is_store;
            r_idx2    <= w_k + (IDX_W)'(1);
            r_hi_be   <= w_be8[7:4];
            r_hi_dat  <= w_st64[63:32];
         end
      end
   end

endmodule

// File: tb/tb_data_mem_unit.sv
// Bench for data_mem_unit: directed vector table, hand-written multi-cycle sequences and random ops vs a byte-array model.
module tb_data_mem_unit;
   localparam int DW  = 64;
   localparam int TOT = DW * 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        is_load = 1'b0;
   logic        is_store = 1'b0;
   logic [2:0]  funct3 = 3'b000;
   logic [31:0] addr = '0;
   logic [31:0] w_data = '0;
   logic [31:0] r_data;
   logic        r_valid;
   logic        stall;
   logic        err;

   int n_checks = 0;
   int n_err = 0;

   logic [7:0]  mm [TOT];
   logic [31:0] m_last = '0;

   data_mem_unit #(.XLEN(32), .DEPTH_WORDS(DW)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .is_load(is_load),
      .is_store(is_store), .funct3(funct3), .addr(addr), .w_data(w_data),
      .r_data(r_data), .r_valid(r_valid), .stall(stall), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        ld;
      logic        st;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] wd;
      logic        chk;
      logic [31:0] exp;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(logic ld, logic st, logic [2:0] f3, logic [31:0] a,
                               logic [31:0] wd, logic chk, logic [31:0] exp);
      vec_t v;
      v.ld = ld; v.st = st; v.f3 = f3; v.a = a; v.wd = wd; v.chk = chk; v.exp = exp;
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic drive(input logic v, input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd);
      req_valid = v; is_load = ld; is_store = st; funct3 = f3; addr = a; w_data = wd;
   endtask

   // Memory as a flat byte array indexed by byte address modulo its size.
   task automatic model_op(input logic ld, input logic st, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd,
                           output logic e_err, output logic e_split,
                           output logic e_load, output logic [31:0] e_val);
      int sz;
      int base;
      logic [31:0] v;
      e_err = 1'b0; e_split = 1'b0; e_load = 1'b0; e_val = m_last;
      if (!ld && !st) return;
      if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7 || (ld && st) || (st && f3[2])) begin
         e_err = 1'b1;
         return;
      end
      sz = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
      base = int'(a % TOT);
      e_split = ((base % 4) + sz) > 4;
      if (st) begin
         for (int i = 0; i < sz; i++) mm[(base + i) % TOT] = wd[8*i +: 8];
      end else begin
         v = '0;
         for (int i = 0; i < sz; i++) v[8*i +: 8] = mm[(base + i) % TOT];
         if (!f3[2] && sz == 1) v = {{24{v[7]}}, v[7:0]};
         if (!f3[2] && sz == 2) v = {{16{v[15]}}, v[15:0]};
         e_load = 1'b1;
         e_val  = v;
         m_last = v;
      end
   endtask

   task automatic run_op(input string tag, input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, output logic [31:0] got);
      logic e_err, e_split, e_load;
      logic [31:0] e_val;
      logic e1, e2, s1, v1, v2;
      model_op(ld, st, f3, a, wd, e_err, e_split, e_load, e_val);
      drive(1'b1, ld, st, f3, a, wd);
      tick();
      drive(1'b0, 1'b0, 1'b0, 3'b000, '0, '0);
      e1 = err; s1 = stall;
      tick();
      v1 = r_valid; e2 = err;
      tick();
      v2 = r_valid; got = r_data;
      check({tag, "/err"}, {30'b0, e1, e2}, {30'b0, e_err, 1'b0});
      check({tag, "/stall"}, {31'b0, s1}, {31'b0, e_split});
      check({tag, "/rvalid"}, {30'b0, v1, v2},
            e_load ? (e_split ? 32'd1 : 32'd2) : 32'd0);
      check({tag, "/rdata"}, got, e_val);
   endtask

   initial begin
      logic [31:0] got;
      logic e_err, e_split, e_load;
      logic [31:0] e_val;
      int r;

      repeat (3) tick();
      check("reset/r_data", r_data, 32'h0);
      check("reset/r_valid", {31'b0, r_valid}, 32'h0);
      check("reset/stall", {31'b0, stall}, 32'h0);
      check("reset/err", {31'b0, err}, 32'h0);
      rst_n = 1'b1;

      for (int w = 0; w < DW; w++) begin
         drive(1'b1, 1'b0, 1'b1, 3'b010, 32'(w * 4), 32'h0);
         tick();
      end
      drive(1'b0, 1'b0, 1'b0, 3'b000, '0, '0);
      for (int i = 0; i < TOT; i++) mm[i] = 8'h00;
      tick();

      tbl.push_back(mk(0, 1, 3'b010, 32'h10, 32'h8765_4321, 0, 0));
      tbl.push_back(mk(1, 0, 3'b010, 32'h10, 0, 1, 32'h8765_4321));
      tbl.push_back(mk(1, 0, 3'b000, 32'h13, 0, 1, 32'hFFFF_FF87));
      tbl.push_back(mk(1, 0, 3'b100, 32'h13, 0, 1, 32'h0000_0087));
      tbl.push_back(mk(1, 0, 3'b001, 32'h12, 0, 1, 32'hFFFF_8765));
      tbl.push_back(mk(1, 0, 3'b101, 32'h12, 0, 1, 32'h0000_8765));
      tbl.push_back(mk(0, 1, 3'b010, 32'h20, 32'h1122_3344, 0, 0));
      tbl.push_back(mk(0, 1, 3'b000, 32'h21, 32'h0000_00AA, 0, 0));
      tbl.push_back(mk(1, 0, 3'b010, 32'h20, 0, 1, 32'h1122_AA44));
      tbl.push_back(mk(0, 1, 3'b001, 32'h22, 32'h0000_BEEF, 0, 0));
      tbl.push_back(mk(1, 0, 3'b010, 32'h20, 0, 1, 32'hBEEF_AA44));
      tbl.push_back(mk(0, 1, 3'b010, 32'h31, 32'hDDCC_BBAA, 0, 0));
      tbl.push_back(mk(1, 0, 3'b010, 32'h30, 0, 1, 32'hCCBB_AA00));
      tbl.push_back(mk(1, 0, 3'b010, 32'h34, 0, 1, 32'h0000_00DD));
      tbl.push_back(mk(1, 0, 3'b010, 32'h31, 0, 1, 32'hDDCC_BBAA));
      tbl.push_back(mk(1, 0, 3'b001, 32'h33, 0, 1, 32'hFFFF_DDCC));
      tbl.push_back(mk(1, 0, 3'b101, 32'h33, 0, 1, 32'h0000_DDCC));
      tbl.push_back(mk(1, 0, 3'b011, 32'h20, 0, 1, 32'h0000_DDCC));
      tbl.push_back(mk(0, 1, 3'b110, 32'h20, 32'hFFFF_FFFF, 0, 0));
      tbl.push_back(mk(1, 1, 3'b010, 32'h20, 32'hFFFF_FFFF, 0, 0));
      tbl.push_back(mk(0, 1, 3'b101, 32'h20, 32'hFFFF_FFFF, 0, 0));
      tbl.push_back(mk(1, 0, 3'b010, 32'h20, 0, 1, 32'hBEEF_AA44));
      tbl.push_back(mk(0, 1, 3'b001, 32'(TOT - 1), 32'h0000_1234, 0, 0));
      tbl.push_back(mk(1, 0, 3'b010, 32'(TOT - 4), 0, 1, 32'h3400_0000));
      tbl.push_back(mk(1, 0, 3'b010, 32'h0, 0, 1, 32'h0000_0012));
      tbl.push_back(mk(1, 0, 3'b010, 32'h1000_0020, 0, 1, 32'hBEEF_AA44));

      foreach (tbl[i]) begin
         run_op($sformatf("vec%0d", i), tbl[i].ld, tbl[i].st, tbl[i].f3, tbl[i].a, tbl[i].wd, got);
         if (tbl[i].chk) check($sformatf("vec%0d/table", i), got, tbl[i].exp);
      end

      // Request presented during the stall cycle must be dropped.
      model_op(0, 1, 3'b010, 32'h41, 32'h5566_7788, e_err, e_split, e_load, e_val);
      drive(1'b1, 1'b0, 1'b1, 3'b010, 32'h41, 32'h5566_7788);
      tick();
      check("drop/stall", {31'b0, stall}, 32'h1);
      drive(1'b1, 1'b0, 1'b1, 3'b010, 32'h48, 32'hFFFF_FFFF);
      tick();
      drive(1'b0, 1'b0, 1'b0, 3'b000, '0, '0);
      check("drop/stall_end", {31'b0, stall}, 32'h0);
      check("drop/err", {31'b0, err}, 32'h0);
      tick();
      run_op("drop/ld48", 1, 0, 3'b010, 32'h48, 0, got);
      check("drop/ld48_val", got, 32'h0);
      run_op("drop/ld41", 1, 0, 3'b010, 32'h41, 0, got);
      check("drop/ld41_val", got, 32'h5566_7788);

      // Reset in the stall cycle of a split store: only the low part lands.
      drive(1'b1, 1'b0, 1'b1, 3'b010, 32'h51, 32'h1122_3344);
      tick();
      drive(1'b0, 1'b0, 1'b0, 3'b000, '0, '0);
      check("rst/stall", {31'b0, stall}, 32'h1);
      rst_n = 1'b0;
      tick();
      check("rst/stall_clr", {31'b0, stall}, 32'h0);
      check("rst/rvalid", {31'b0, r_valid}, 32'h0);
      check("rst/rdata", r_data, 32'h0);
      rst_n = 1'b1;
      mm[8'h51] = 8'h44; mm[8'h52] = 8'h33; mm[8'h53] = 8'h22;
      m_last = '0;
      tick();
      run_op("rst/ld50", 1, 0, 3'b010, 32'h50, 0, got);
      check("rst/ld50_val", got, 32'h2233_4400);
      run_op("rst/ld54", 1, 0, 3'b010, 32'h54, 0, got);
      check("rst/ld54_val", got, 32'h0);

      // Back-to-back store then loads, one per cycle.
      model_op(0, 1, 3'b010, 32'h60, 32'hCAFE_F00D, e_err, e_split, e_load, e_val);
      model_op(1, 0, 3'b010, 32'h60, 0, e_err, e_split, e_load, e_val);
      model_op(1, 0, 3'b010, 32'h10, 0, e_err, e_split, e_load, e_val);
      drive(1'b1, 1'b0, 1'b1, 3'b010, 32'h60, 32'hCAFE_F00D);
      tick();
      drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h60, 32'h0);
      tick();
      drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
      check("b2b/rv0", {31'b0, r_valid}, 32'h0);
      tick();
      drive(1'b0, 1'b0, 1'b0, 3'b000, '0, '0);
      check("b2b/rv1", {31'b0, r_valid}, 32'h1);
      check("b2b/d1", r_data, 32'hCAFE_F00D);
      tick();
      check("b2b/rv2", {31'b0, r_valid}, 32'h1);
      check("b2b/d2", r_data, 32'h8765_4321);
      tick();
      check("b2b/rv3", {31'b0, r_valid}, 32'h0);
      tick();
      check("b2b/hold", r_data, 32'h8765_4321);

      for (int n = 0; n < 300; n++) begin
         logic ld, st;
         r = $urandom_range(0, 9);
         ld = (r == 0) || (r >= 2 && r <= 5);
         st = (r == 0) || (r >= 6);
         run_op($sformatf("rnd%0d", n), ld, st, 3'($urandom_range(0, 7)), $urandom, $urandom, got);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule
